// File: rtl/dft_engine.sv
// Direct-form N-point DFT: reads x[n] and twiddles, multiply-accumulates each bin, writes X[k] back.
// Build option: define DFT_SAT_EN to saturate outputs to 32 bits instead of wrapping.
module dft_engine #(
  parameter int sample           = 8,
  parameter int n_bit_for_sample = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    ram_wr_sel,
  output logic [1:0]                    ram_rd_sel,
  output logic                          ram_wr_en,
  output logic                          ram_sub_en,
  output logic [n_bit_for_sample-1:0]   ram_addr,
  output logic signed [31:0]            ram_wdata_1,
  output logic signed [31:0]            ram_wdata_2,
  input  logic signed [31:0]            ram_rdata_1,
  input  logic signed [31:0]            ram_rdata_2,
  output logic [n_bit_for_sample-1:0]   tw_addr,
  input  logic signed [15:0]            tw_cos,
  input  logic signed [15:0]            tw_sin
);

  localparam int ACC_W = 49 + n_bit_for_sample;
  localparam logic [n_bit_for_sample-1:0] LAST = n_bit_for_sample'(sample - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [n_bit_for_sample-1:0] r_k;
  logic [n_bit_for_sample-1:0] r_n;
  logic [n_bit_for_sample-1:0] r_idx;
  logic                        r_drain;
  logic                        r_v1;
  logic                        r_v2;
  logic signed [48:0]          r_pr;
  logic signed [48:0]          r_pi;
  logic signed [ACC_W-1:0]     r_acc_r;
  logic signed [ACC_W-1:0]     r_acc_i;

  logic [47:0] w_xr_c;
  logic [47:0] w_xi_s;
  logic [47:0] w_xi_c;
  logic [47:0] w_xr_s;
  logic [48:0] w_pr;
  logic [48:0] w_pi;

  // Operands sign-extended to the product width so an unsigned multiply yields the signed product.
  assign w_xr_c = {{16{ram_rdata_1[31]}}, ram_rdata_1} * {{32{tw_cos[15]}}, tw_cos};
  assign w_xi_s = {{16{ram_rdata_2[31]}}, ram_rdata_2} * {{32{tw_sin[15]}}, tw_sin};
  assign w_xi_c = {{16{ram_rdata_2[31]}}, ram_rdata_2} * {{32{tw_cos[15]}}, tw_cos};
  assign w_xr_s = {{16{ram_rdata_1[31]}}, ram_rdata_1} * {{32{tw_sin[15]}}, tw_sin};
  assign w_pr   = {w_xr_c[47], w_xr_c} + {w_xi_s[47], w_xi_s};
  assign w_pi   = {w_xi_c[47], w_xi_c} - {w_xr_s[47], w_xr_s};

  assign ram_wr_sel = 2'b10;
  assign ram_rd_sel = 2'b00;

  function automatic logic [31:0] f_reduce(input logic signed [ACC_W-1:0] a);
`ifdef DFT_SAT_EN
    logic signed [ACC_W-1:0] s;
    s = a >>> 14;
    if ((s[ACC_W-1:31] == '0) || (s[ACC_W-1:31] == '1))
      f_reduce = s[31:0];
    else
      f_reduce = s[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    f_reduce = 32'(a >>> 14);
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    ram_wr_en    = 1'b0;
    ram_sub_en   = 1'b0;
    ram_addr     = '0;
    tw_addr      = '0;
    ram_wdata_1  = '0;
    ram_wdata_2  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_READ;
      end
      S_READ: begin
        busy       = 1'b1;
        ram_sub_en = 1'b1;
        ram_addr   = r_n;
        tw_addr    = r_idx;
        if (r_n == LAST) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        ram_sub_en = 1'b1;
        if (r_drain) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        ram_sub_en  = 1'b1;
        ram_wr_en   = 1'b1;
        ram_addr    = r_k;
        ram_wdata_1 = f_reduce(r_acc_r);
        ram_wdata_2 = f_reduce(r_acc_i);
        w_state_next = (r_k == LAST) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_drain <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_pr    <= '0;
      r_pi    <= '0;
      r_acc_r <= '0;
      r_acc_i <= '0;
    end else begin
      // v1: RAM/ROM data on the bus this cycle; v2: product register holds a real sample.
      r_v1 <= (r_state == S_READ);
      r_v2 <= r_v1;
      if (r_v1) begin
        r_pr <= w_pr;
        r_pi <= w_pi;
      end
      if (r_v2) begin
        r_acc_r <= r_acc_r + {{n_bit_for_sample{r_pr[48]}}, r_pr};
        r_acc_i <= r_acc_i + {{n_bit_for_sample{r_pi[48]}}, r_pi};
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_drain <= 1'b0;
            r_acc_r <= '0;
            r_acc_i <= '0;
          end
        end
        S_READ: begin
          r_n   <= r_n + 1'b1;
          r_idx <= r_idx + r_k;  // (k*n) mod N, wrapped by width
        end
        S_DRAIN: r_drain <= ~r_drain;
        S_WRITE: begin
          r_acc_r <= '0;
          r_acc_i <= '0;
          r_drain <= 1'b0;
          r_n     <= '0;
          r_idx   <= '0;
          if (r_k != LAST) r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_engine.sv
// Self-checking bench for dft_engine: RAM/ROM models, direct DFT reference model, directed vectors.
module tb_dft_engine;
  localparam int N  = 8;
  localparam int LG = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done, ram_wr_en, ram_sub_en;
  logic [1:0]         ram_wr_sel, ram_rd_sel;
  logic [LG-1:0]      ram_addr, tw_addr;
  logic signed [31:0] ram_wdata_1, ram_wdata_2;
  logic signed [31:0] ram_rdata_1 = '0, ram_rdata_2 = '0;
  logic signed [15:0] tw_cos = '0, tw_sin = '0;

  dft_engine #(.sample(N), .n_bit_for_sample(LG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_wr_sel(ram_wr_sel), .ram_rd_sel(ram_rd_sel), .ram_wr_en(ram_wr_en),
    .ram_sub_en(ram_sub_en), .ram_addr(ram_addr), .ram_wdata_1(ram_wdata_1),
    .ram_wdata_2(ram_wdata_2), .ram_rdata_1(ram_rdata_1), .ram_rdata_2(ram_rdata_2),
    .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin)
  );

  always #5 clk = ~clk;

  int cos_tab[N] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
  int sin_tab[N] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

  logic signed [31:0] xr_mem[N];
  logic signed [31:0] xi_mem[N];
  logic signed [31:0] Xr_mem[N];
  logic signed [31:0] Xi_mem[N];
  logic signed [31:0] exp_r[N];
  logic signed [31:0] exp_i[N];
  logic               clr_x = 1'b0;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr_k = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Registered RAM and twiddle ROM, one-cycle read latency.
  always @(posedge clk) begin
    ram_rdata_1 <= xr_mem[ram_addr];
    ram_rdata_2 <= xi_mem[ram_addr];
    tw_cos      <= 16'(cos_tab[tw_addr]);
    tw_sin      <= 16'(sin_tab[tw_addr]);
    if (clr_x) begin
      for (int i = 0; i < N; i++) begin
        Xr_mem[i] <= '0;
        Xi_mem[i] <= '0;
      end
    end else if (ram_wr_en) begin
      Xr_mem[ram_addr] <= ram_wdata_1;
      Xi_mem[ram_addr] <= ram_wdata_2;
    end
  end

  function automatic logic [31:0] reduce(input longint v);
    longint hi, lo;
    hi = (longint'(1) << 31) - 1;
    lo = -(longint'(1) << 31);
`ifdef DFT_SAT_EN
    if (v > hi) return 32'h7FFF_FFFF;
    if (v < lo) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  // Reference: direct DFT sum over the Q2.14 twiddle table.
  task automatic compute_model();
    for (int k = 0; k < N; k++) begin
      longint sr, si;
      sr = 0;
      si = 0;
      for (int n = 0; n < N; n++) begin
        int m;
        m = (k * n) % N;
        sr += longint'(xr_mem[n]) * cos_tab[m] + longint'(xi_mem[n]) * sin_tab[m];
        si += longint'(xi_mem[n]) * cos_tab[m] - longint'(xr_mem[n]) * sin_tab[m];
      end
      exp_r[k] = reduce(sr >>> 14);
      exp_i[k] = reduce(si >>> 14);
    end
  endtask

  // Per-cycle compare process against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_k = 0;
    end else begin
      check("sub_en_vs_busy", 32'(ram_sub_en), 32'(busy));
      check("wr_sel", 32'(ram_wr_sel), 32'd2);
      check("rd_sel", 32'(ram_rd_sel), 32'd0);
      if (done) done_cnt++;
      if (ram_wr_en) begin
        check("wr_addr", 32'(ram_addr), wr_k);
        check("wdata_real", ram_wdata_1, exp_r[ram_addr]);
        check("wdata_imag", ram_wdata_2, exp_i[ram_addr]);
        $display("write k=%0d X_real=%0d X_imag=%0d", ram_addr, ram_wdata_1, ram_wdata_2);
        wr_k = (wr_k + 1) % N;
        wr_cnt++;
      end
    end
  end

  task automatic set_x(input int sel);
    for (int n = 0; n < N; n++) begin
      case (sel)
        0: begin xr_mem[n] = (n == 0) ? 32'sd1000 : 32'sd0; xi_mem[n] = '0; end
        1: begin xr_mem[n] = 32'sd100; xi_mem[n] = '0; end
        2: begin xr_mem[n] = (n % 2 == 1) ? -32'sd50 : 32'sd50; xi_mem[n] = '0; end
        3: begin xr_mem[n] = 32'h7FFF_FFFF; xi_mem[n] = '0; end
        default: begin xr_mem[n] = 32'(1000 * n - 3000); xi_mem[n] = 32'(700 - 200 * n); end
      endcase
    end
  endtask

  task automatic kick();
    clr_x = 1'b1;
    @(negedge clk);
    clr_x = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_dft(input string nm, input int restart_at);
    int  cyc, wr0;
    logic busy_ok;
    compute_model();
    wr0 = wr_cnt;
    kick();
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({nm, " busy_window"}, 32'(busy_ok), 32'd1);
    check({nm, " done_cycle"}, cyc, 32'd89);
    check({nm, " busy_at_done"}, 32'(busy), 32'd0);
    check({nm, " writes"}, wr_cnt - wr0, 32'd8);
    @(negedge clk);
    check({nm, " done_pulse_width"}, 32'(done), 32'd0);
    $display("run %s: done at cycle %0d, %0d writes", nm, cyc, wr_cnt - wr0);
  endtask

  initial begin
    int d0, w0;
    set_x(0);
    for (int i = 0; i < N; i++) begin
      exp_r[i] = '0;
      exp_i[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst wr_en", 32'(ram_wr_en), 32'd0);
    check("rst sub_en", 32'(ram_sub_en), 32'd0);
    check("rst addr", 32'(ram_addr), 32'd0);
    check("rst tw_addr", 32'(tw_addr), 32'd0);
    check("rst wdata1", ram_wdata_1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_x(0);
    run_dft("impulse", 0);
    check("impulse X_real[0]", Xr_mem[0], 32'd1000);
    check("impulse X_real[5]", Xr_mem[5], 32'd1000);
    check("impulse X_imag[3]", Xi_mem[3], 32'd0);

    set_x(1);
    run_dft("dc", 0);
    check("dc X_real[0]", Xr_mem[0], 32'd800);
    check("dc X_real[3]", Xr_mem[3], 32'd0);
    check("dc X_imag[2]", Xi_mem[2], 32'd0);

    set_x(2);
    run_dft("alternating", 0);
    check("alt X_real[4]", Xr_mem[4], 32'd400);
    check("alt X_real[0]", Xr_mem[0], 32'd0);
    check("alt X_real[2]", Xr_mem[2], 32'd0);

    set_x(3);
    run_dft("overflow", 0);
`ifdef DFT_SAT_EN
    check("overflow X_real[0]", Xr_mem[0], 32'h7FFF_FFFF);
`else
    check("overflow X_real[0]", Xr_mem[0], 32'hFFFF_FFF8);
`endif

    set_x(4);
    d0 = done_cnt;
    w0 = wr_cnt;
    run_dft("restart", 10);
    repeat (30) @(negedge clk);
    check("restart done_count", done_cnt - d0, 32'd1);
    check("restart write_count", wr_cnt - w0, 32'd8);

    set_x(4);
    compute_model();
    w0 = wr_cnt;
    d0 = done_cnt;
    kick();
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort wr_en", 32'(ram_wr_en), 32'd0);
    check("abort sub_en", 32'(ram_sub_en), 32'd0);
    check("abort addr", 32'(ram_addr), 32'd0);
    check("abort tw_addr", 32'(tw_addr), 32'd0);
    check("abort wdata2", ram_wdata_2, 32'd0);
    check("abort writes_before", wr_cnt - w0, 32'd2);
    repeat (20) @(negedge clk);
    check("abort writes_after", wr_cnt - w0, 32'd2);
    check("abort no_done", done_cnt - d0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("abort: reset at cycle 30, %0d writes kept", wr_cnt - w0);

    set_x(0);
    run_dft("post_reset_impulse", 0);
    check("post_reset X_real[7]", Xr_mem[7], 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/dft_engine.md
Name: dft_engine

Overview:
- Direct-form N-point DFT compute stage, sitting directly downstream of the local sample/result RAM.
- Reads x_real/x_imag from the RAM and fetches twiddles from an external registered cos/sin ROM.
- Computes X[k] = sum over n of x[n]*e^(-j2πkn/N) by sequential multiply-accumulate.
- Writes X_real/X_imag back into the same RAM; one start pulse computes all N bins.

Parameters:
- sample, 8, number of points N; must be a power of two.
- n_bit_for_sample, 3, log2(sample); width of address and twiddle index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to compute all bins; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final bin is written
- ram_wr_sel  out  2  RAM write select; constant 2'b10 (X bank, real on data_in_1)
- ram_rd_sel  out  2  RAM read select; constant 2'b00 (x bank)
- ram_wr_en  out  1  RAM write strobe
- ram_sub_en  out  1  RAM dual-lane enable; 1 whenever busy
- ram_addr  out  n_bit_for_sample  RAM address (read n, or write k)
- ram_wdata_1  out  32 signed  X_real[k]
- ram_wdata_2  out  32 signed  X_imag[k]
- ram_rdata_1  in  32 signed  x_real[n], valid 1 cycle after ram_addr
- ram_rdata_2  in  32 signed  x_imag[n], valid 1 cycle after ram_addr
- tw_addr  out  n_bit_for_sample  twiddle index m = (k*n) mod N
- tw_cos  in  16 signed  Q2.14 cos(2πm/N), valid 1 cycle after tw_addr
- tw_sin  in  16 signed  Q2.14 sin(2πm/N), valid 1 cycle after tw_addr

Behaviour:
- Reset (async, rst_n low): state IDLE. busy, done, ram_wr_en, ram_sub_en = 0. ram_addr, tw_addr, ram_wdata_1/2 = 0. Accumulators, k, n, index registers = 0.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 → READ with k=0, n=0, idx=0, accumulators cleared.
  - start in any other state is ignored.
- READ (N cycles):
  - Drive ram_addr=n and tw_addr=idx.
  - Each cycle: n++, idx = (idx+k) mod N (wrap by bit truncation).
  - After n=N-1 → DRAIN.
- Datapath pipeline:
  - Stage 1: RAM and ROM return data 1 cycle after the address.
  - Stage 2: registered products pr = xr*c + xi*s and pi = xi*c − xr*s (49-bit signed).
  - Stage 3: accR += pr and accI += pi. Accumulator width ACC_W = 49 + n_bit_for_sample.
  - A valid bit tracks each stage; only valid products accumulate.
- DRAIN: 2 cycles, letting the last sample reach the accumulators, then → WRITE.
- WRITE (1 cycle):
  - ram_wr_en=1, ram_addr=k.
  - ram_wdata_1 = accR >>> 14 and ram_wdata_2 = accI >>> 14 (arithmetic shift, truncation toward −inf), reduced to 32 bits per the Optional Feature.
  - Accumulators cleared.
  - k==N-1 → DONE; else k++, n=0, idx=0, → READ.
- DONE: done=1 and busy=0 for one cycle, → IDLE.
- Timing:
  - Per bin: N+3 cycles.
  - done asserts exactly N*(N+3)+1 cycles after the start-sampling edge (89 for N=8).
  - busy is high for the N*(N+3) cycles in between.
- Control outputs:
  - ram_wr_en is high only in WRITE.
  - ram_sub_en is high in READ, DRAIN and WRITE.
  - ram_wr_sel and ram_rd_sel are constant.
- Reset mid-operation: immediate abort. No further writes are issued; partially written bins are left as-is. done is not pulsed.
- Input data is read only in READ; RAM contents must be stable while busy.

Optional Feature:
- Macro: DFT_SAT_EN.
- Defined: the shifted result is saturated to [−2^31, 2^31−1] before output.
- Undefined: the shifted result is truncated to its low 32 bits (two's-complement wrap).

Test Plan:
- Impulse: x_real[0]=1000, all other x=0, start → every X_real[k]=1000 and X_imag[k]=0; done at cycle 89.
- DC: x_real[n]=100 for all n → X_real[0]=800; all other bins 0 real and 0 imag (exact, since the Q2.14 twiddle table is symmetric).
- Alternating: x_real[n]=50*(−1)^n → X_real[4]=400; all other bins 0.
- Overflow: x_real[n]=32'h7FFFFFFF for all n → X_real[0]=32'h7FFFFFFF with DFT_SAT_EN; 32'hFFFFFFF8 without it.
- Start while busy: a second start at cycle 10 is ignored → exactly one done and 8 writes total.
- Reset mid-op: rst_n low at cycle 30 → all outputs 0 immediately, no writes after reset, busy=0. A fresh start then completes normally.
